// File: rtl/uart_rx_if.sv
// Receive-side handshake bundle for uart_rx: byte holding register outputs,
// status pulses and the consumer's ready.
interface uart_rx_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  modport master (
    output data,
    output valid,
    output frame_error,
    output overrun,
    output busy,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  frame_error,
    input  overrun,
    input  busy,
    output ready
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM and a
// single-entry holding register with valid/ready handoff.
module uart_rx #(
  parameter int CLOCK_FREQUENCY = 27000000,
  parameter int BAUD_RATE       = 115200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  uart_rx_if.master bus
);

  localparam int BAUD_DIVISOR = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int HALF_DIVISOR = BAUD_DIVISOR / 2;
  localparam int CNT_W        = $clog2(BAUD_DIVISOR) + 1;

  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIVISOR - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIVISOR - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t           state_q, state_d;
  logic             rx_meta, rx_s;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_q;
  logic             deliver_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             frame_error_q;
  logic             overrun_q;

  logic             cnt_clr;
  logic             idx_clr;
  logic             bit_sample;
  logic             stop_ok;
  logic             stop_bad;

  always_comb begin
    state_d    = state_q;
    cnt_clr    = 1'b0;
    idx_clr    = 1'b0;
    bit_sample = 1'b0;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_clr = 1'b1;
        end
      end
      S_START: begin
        if (baud_cnt == HALF_LAST) begin
          cnt_clr = 1'b1;
          idx_clr = 1'b1;
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (baud_cnt == FULL_LAST) begin
          cnt_clr    = 1'b1;
          bit_sample = 1'b1;
          if (bit_idx == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_cnt == FULL_LAST) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            stop_ok = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rx_meta       <= 1'b1;
      rx_s          <= 1'b1;
      baud_cnt      <= '0;
      bit_idx       <= '0;
      shift_q       <= '0;
      deliver_q     <= 1'b0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      state_q <= state_d;

      // Counter idles at zero outside the timed states so it can never wrap.
      if (cnt_clr || state_q == S_IDLE || state_q == S_WAIT_HIGH)
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + CNT_ONE;

      if (idx_clr)
        bit_idx <= '0;
      else if (bit_sample)
        bit_idx <= bit_idx + 3'd1;

      if (bit_sample) shift_q[bit_idx] <= rx_s;

      deliver_q     <= stop_ok;
      frame_error_q <= stop_bad;
      overrun_q     <= deliver_q && valid_q && !bus.ready;

      // A handshake in the delivery cycle frees the register for the new byte.
      if (deliver_q && (!valid_q || bus.ready)) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (valid_q && bus.ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.data        = data_q;
  assign bus.valid       = valid_q;
  assign bus.frame_error = frame_error_q;
  assign bus.overrun     = overrun_q;
  assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames driven bit by bit, outputs
// compared against expectations derived from the byte value and frame timing.
module tb_uart_rx;

  localparam int CLK_HZ    = 27000000;
  localparam int BAUD      = 115200;
  localparam int DIV       = CLK_HZ / BAUD;
  localparam int HALF      = DIV / 2;
  localparam int FRAME     = 10 * DIV;
  // rx falls after edge F; two sync edges, then IDLE detects on edge F+3.
  localparam int VALID_OFS = 3 + HALF + 9 * DIV + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  int         q_vrise[$];
  logic [7:0] q_vdata[$];
  int         q_fe[$];
  int         q_ov[$];
  logic       v_prev = 1'b0;

  uart_rx_if bus ();

  uart_rx #(
    .CLOCK_FREQUENCY(CLK_HZ),
    .BAUD_RATE(BAUD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx(rx),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.valid && !v_prev) begin
        q_vrise.push_back(cyc);
        q_vdata.push_back(bus.data);
      end
      if (bus.frame_error) q_fe.push_back(cyc);
      if (bus.overrun) q_ov.push_back(cyc);
    end
    v_prev = bus.valid;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    q_vrise.delete();
    q_vdata.delete();
    q_fe.delete();
    q_ov.delete();
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop, output int fall);
    fall = cyc;
    rx = 1'b0;
    step(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(DIV);
    end
    rx = stop;
    step(DIV);
  endtask

  task automatic consume();
    bus.ready = 1'b1;
    step(1);
    bus.ready = 1'b0;
    step(2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rx = 1'($urandom_range(0, 1));
      step(1);
    end
    checks++; if (bus.data !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 00", bus.data); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", bus.valid); end
    checks++; if (bus.frame_error !== 1'b0) begin errors++; $display("FAIL reset_fe: got %0b expected 0", bus.frame_error); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_ov: got %0b expected 0", bus.overrun); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
    rx = 1'b1;
    rst_n = 1'b1;
    step(5);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %0b expected 0", bus.busy); end
    clear_events();
  endtask

  task automatic test_single();
    int f, lat;
    clear_events();
    drive_frame(8'h54, 1'b1, f);
    step(100);
    lat = (q_vrise.size() > 0) ? q_vrise[0] - f : -1;
    checks++; if (q_vrise.size() !== 1) begin errors++; $display("FAIL single_rises: got %0d expected 1", q_vrise.size()); end
    checks++; if (lat !== VALID_OFS) begin errors++; $display("FAIL single_latency: got %0d expected %0d", lat, VALID_OFS); end
    checks++; if (bus.data !== 8'h54) begin errors++; $display("FAIL single_data: got %0h expected 54", bus.data); end
    step(500);
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL single_hold: got %0b expected 1", bus.valid); end
    bus.ready = 1'b1;
    step(1);
    bus.ready = 1'b0;
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL single_drop: got %0b expected 0", bus.valid); end
    checks++; if (bus.data !== 8'h54) begin errors++; $display("FAIL single_data_hold: got %0h expected 54", bus.data); end
    checks++; if (q_fe.size() + q_ov.size() !== 0) begin errors++; $display("FAIL single_pulses: got %0d expected 0", q_fe.size() + q_ov.size()); end
  endtask

  task automatic test_glitch();
    clear_events();
    rx = 1'b0;
    step(50);
    rx = 1'b1;
    step(50);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_mid: got %0b expected 1", bus.busy); end
    step(25);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %0b expected 0", bus.busy); end
    step(3000);
    checks++; if (q_vrise.size() + q_fe.size() + q_ov.size() !== 0) begin errors++; $display("FAIL glitch_events: got %0d expected 0", q_vrise.size() + q_fe.size() + q_ov.size()); end
  endtask

  task automatic test_frame_error();
    int f, ofs;
    clear_events();
    drive_frame(8'hA5, 1'b0, f);
    step(1000);
    ofs = (q_fe.size() > 0) ? q_fe[0] - f : -1;
    checks++; if (q_fe.size() !== 1) begin errors++; $display("FAIL fe_count: got %0d expected 1", q_fe.size()); end
    checks++; if (ofs != VALID_OFS - 1 && ofs != VALID_OFS) begin errors++; $display("FAIL fe_time: got %0d expected %0d or %0d", ofs, VALID_OFS - 1, VALID_OFS); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL fe_valid: got %0b expected 0", bus.valid); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL fe_busy_break: got %0b expected 1", bus.busy); end
    rx = 1'b1;
    step(5);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL fe_busy_release: got %0b expected 0", bus.busy); end
    step(2 * DIV);
    checks++; if (q_vrise.size() !== 0) begin errors++; $display("FAIL fe_no_valid: got %0d expected 0", q_vrise.size()); end
  endtask

  task automatic test_back_to_back();
    int f1, f2, fd, ov_ofs, lat;
    clear_events();
    drive_frame(8'h31, 1'b1, f1);
    drive_frame(8'h32, 1'b1, f2);
    step(100);
    ov_ofs = (q_ov.size() > 0) ? q_ov[0] - f2 : -1;
    checks++; if (bus.data !== 8'h31) begin errors++; $display("FAIL b2b_data_keep: got %0h expected 31", bus.data); end
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %0b expected 1", bus.valid); end
    checks++; if (q_ov.size() !== 1) begin errors++; $display("FAIL b2b_ov_count: got %0d expected 1", q_ov.size()); end
    checks++; if (ov_ofs !== VALID_OFS) begin errors++; $display("FAIL b2b_ov_time: got %0d expected %0d", ov_ofs, VALID_OFS); end
    consume();

    clear_events();
    f1 = cyc;
    f2 = f1 + FRAME;
    fork
      begin
        drive_frame(8'h31, 1'b1, fd);
        drive_frame(8'h32, 1'b1, fd);
      end
      begin
        while (cyc < f2 + VALID_OFS - 1) step(1);
        bus.ready = 1'b1;
        step(1);
        bus.ready = 1'b0;
      end
    join
    step(100);
    lat = (q_vrise.size() > 0) ? q_vrise[0] - f1 : -1;
    checks++; if (bus.data !== 8'h32) begin errors++; $display("FAIL b2b_hs_data: got %0h expected 32", bus.data); end
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL b2b_hs_valid: got %0b expected 1", bus.valid); end
    checks++; if (q_ov.size() !== 0) begin errors++; $display("FAIL b2b_hs_ov: got %0d expected 0", q_ov.size()); end
    checks++; if (lat !== VALID_OFS) begin errors++; $display("FAIL b2b_hs_first: got %0d expected %0d", lat, VALID_OFS); end
    consume();
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    int f, lat;
    b = 8'h7E;
    clear_events();
    rx = 1'b0;
    step(DIV);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      step(DIV);
    end
    rx = b[4];
    step(100);
    rst_n = 1'b0;
    rx = 1'b1;
    step(5);
    rst_n = 1'b1;
    step(300);
    checks++; if (q_vrise.size() + q_fe.size() + q_ov.size() !== 0) begin errors++; $display("FAIL abort_events: got %0d expected 0", q_vrise.size() + q_fe.size() + q_ov.size()); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b expected 0", bus.busy); end
    drive_frame(8'h0D, 1'b1, f);
    step(100);
    lat = (q_vrise.size() > 0) ? q_vrise[0] - f : -1;
    checks++; if (bus.data !== 8'h0D) begin errors++; $display("FAIL abort_next_data: got %0h expected 0d", bus.data); end
    checks++; if (lat !== VALID_OFS) begin errors++; $display("FAIL abort_next_latency: got %0d expected %0d", lat, VALID_OFS); end
    consume();
  endtask

  task automatic test_random();
    logic [7:0] b, got;
    logic       bad;
    int         f, lat;
    for (int n = 0; n < 6; n++) begin
      step($urandom_range(1, 40));
      b   = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      clear_events();
      drive_frame(b, !bad, f);
      if (bad) begin
        step(50);
        checks++; if (q_fe.size() !== 1 || q_vrise.size() !== 0) begin errors++; $display("FAIL rand_fe[%0d]: got fe=%0d rises=%0d expected 1/0", n, q_fe.size(), q_vrise.size()); end
        rx = 1'b1;
        step(10);
      end else begin
        step(20);
        lat = (q_vrise.size() > 0) ? q_vrise[0] - f : -1;
        got = (q_vdata.size() > 0) ? q_vdata[0] : 8'hxx;
        checks++; if (lat !== VALID_OFS) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, lat, VALID_OFS); end
        checks++; if (got !== b) begin errors++; $display("FAIL rand_data[%0d]: got %0h expected %0h", n, got, b); end
        consume();
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL rand_consume[%0d]: got %0b expected 0", n, bus.valid); end
      end
    end
  endtask

  initial begin
    bus.ready = 1'b0;
    test_reset();
    test_single();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
